// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame decoder.
// Provides the FSM state enum, error codes and the default sync byte.
package uart_frame_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      PAYLOAD,
      CSUM,
      SEND
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_LEN     = 2'd1;
   localparam logic [1:0] ERR_CSUM    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_decoder_if.sv
// Payload byte stream with valid/ready handshake and last flag.
// master: valid/data/last out, ready in; slave: the reverse.
interface uart_frame_decoder_if;

   logic       valid;
   logic       ready;
   logic [7:0] data;
   logic       last;

   modport master (
      output valid,
      output data,
      output last,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      input  last,
      output ready
   );

endinterface

// File: rtl/uart_frame_buf.sv
// Payload buffer: MAX_LEN x 8 register file.
// Ports: clk, wr_en/wr_idx/wr_data write port, rd_idx -> rd_data async read.
module uart_frame_buf #(
   parameter int MAX_LEN = 16,
   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_idx,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] rd_idx,
   output logic [7:0]    rd_data
);

   logic [7:0] mem [MAX_LEN];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_data;
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/uart_frame_decoder.sv
// Framed packet decoder: SYNC, LEN, PAYLOAD[LEN], CSUM (XOR of LEN+payload).
// Ports: clk, rst, rx_valid/rx_data in; out (stream master); frame_err, err_code, drop.
module uart_frame_decoder
   import uart_frame_pkg::*;
#(
   parameter int         MAX_LEN        = 16,
   parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
   parameter int         TIMEOUT_CYCLES = 20000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_valid,
   input  logic [7:0]           rx_data,
   uart_frame_decoder_if.master out,
   output logic                 frame_err,
   output logic [1:0]           err_code,
   output logic                 drop
);

   localparam int IW = $clog2(MAX_LEN + 1);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [7:0]    MAX8 = 8'(MAX_LEN);
   localparam logic [CW-1:0] TSAT = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_CYCLES - 1);

   state_t        state, state_nxt;
   logic [IW-1:0] len, wr_idx, rd_idx;
   logic [7:0]    csum, rd_data;
   logic [CW-1:0] idle_cnt;
   logic          in_frame, tmo, len_bad, wr_en;
   logic          fire, last, err_set;
   logic [1:0]    err_val;

   assign in_frame = (state == LEN) || (state == PAYLOAD) || (state == CSUM);
   // A byte on the limit cycle wins over the timeout
   assign tmo      = in_frame && !rx_valid && (idle_cnt == TLIM);
   assign len_bad  = (rx_data == 8'd0) || (rx_data > MAX8);
   assign last     = (rd_idx == len - 1'b1);
   assign fire     = (state == SEND) && out.ready;

   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      err_set   = 1'b0;
      err_val   = ERR_NONE;
      unique case (state)
         IDLE: begin
            if (rx_valid && rx_data == SYNC_BYTE) state_nxt = LEN;
         end
         LEN: begin
            if (rx_valid) begin
               if (len_bad) begin
                  err_set   = 1'b1;
                  err_val   = ERR_LEN;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = PAYLOAD;
               end
            end else if (tmo) begin
               err_set   = 1'b1;
               err_val   = ERR_TIMEOUT;
               state_nxt = IDLE;
            end
         end
         PAYLOAD: begin
            if (rx_valid) begin
               wr_en = 1'b1;
               if (wr_idx == len - 1'b1) state_nxt = CSUM;
            end else if (tmo) begin
               err_set   = 1'b1;
               err_val   = ERR_TIMEOUT;
               state_nxt = IDLE;
            end
         end
         CSUM: begin
            if (rx_valid) begin
               if (rx_data == csum) begin
                  state_nxt = SEND;
               end else begin
                  err_set   = 1'b1;
                  err_val   = ERR_CSUM;
                  state_nxt = IDLE;
               end
            end else if (tmo) begin
               err_set   = 1'b1;
               err_val   = ERR_TIMEOUT;
               state_nxt = IDLE;
            end
         end
         SEND: begin
            if (fire && last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_err <= 1'b0;
         err_code  <= ERR_NONE;
         drop      <= 1'b0;
         idle_cnt  <= '0;
         len       <= '0;
         wr_idx    <= '0;
         rd_idx    <= '0;
         csum      <= '0;
      end else begin
         frame_err <= err_set;
         if (err_set) err_code <= err_val;
         drop <= (state == SEND) && rx_valid;
         if (!in_frame || rx_valid || tmo) idle_cnt <= '0;
         else if (idle_cnt != TSAT) idle_cnt <= idle_cnt + 1'b1;
         if (state == LEN && rx_valid) begin
            len    <= rx_data[IW-1:0];
            csum   <= rx_data;
            wr_idx <= '0;
         end
         if (wr_en) begin
            csum   <= csum ^ rx_data;
            wr_idx <= wr_idx + 1'b1;
         end
         if (state == CSUM && rx_valid) rd_idx <= '0;
         if (fire) rd_idx <= rd_idx + 1'b1;
      end
   end

   uart_frame_buf #(.MAX_LEN(MAX_LEN)) u_buf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_idx  (wr_idx[AW-1:0]),
      .wr_data (rx_data),
      .rd_idx  (rd_idx[AW-1:0]),
      .rd_data (rd_data)
   );

   // Outputs are forced to zero outside SEND so stale buffer data never leaks
   assign out.valid = (state == SEND);
   assign out.data  = (state == SEND) ? rd_data : 8'h00;
   assign out.last  = (state == SEND) && last;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Self-checking bench for uart_frame_decoder.
// Table-driven cycle vectors plus hand-written timeout and reset sequences.
module tb_uart_frame_decoder;

   localparam int TO = 40;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rdy = 1'b0;
   logic       frame_err;
   logic [1:0] err_code;
   logic       drop;

   int n_cmp = 0;
   int n_bad = 0;

   uart_frame_decoder_if bus ();
   assign bus.ready = rdy;

   uart_frame_decoder #(
      .MAX_LEN        (16),
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .out       (bus),
      .frame_err (frame_err),
      .err_code  (err_code),
      .drop      (drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         v;
      logic [7:0] d;
      bit         r;
      bit         ov;
      logic [7:0] od;
      bit         ol;
      bit         fe;
      logic [1:0] ec;
      bit         dr;
   } vec_t;

   vec_t tv[$];

   function automatic void add(bit v, logic [7:0] d, bit r,
                               bit ov, logic [7:0] od, bit ol,
                               bit fe, logic [1:0] ec, bit dr);
      vec_t e;
      e.v = v; e.d = d; e.r = r;
      e.ov = ov; e.od = od; e.ol = ol;
      e.fe = fe; e.ec = ec; e.dr = dr;
      tv.push_back(e);
   endfunction

   task automatic step(input bit v, input logic [7:0] d, input bit r);
      rx_valid = v;
      rx_data  = d;
      rdy      = r;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic chk(input string nm, input bit ov, input logic [7:0] od,
                      input bit ol, input bit fe, input logic [1:0] ec,
                      input bit dr);
      logic [13:0] got, exp;
      got = {bus.valid, bus.data, bus.last, frame_err, err_code, drop};
      exp = {ov, od, ol, fe, ec, dr};
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got v=%b d=%h l=%b fe=%b ec=%0d dr=%b, need v=%b d=%h l=%b fe=%b ec=%0d dr=%b",
                  nm, got[13], got[12:5], got[4], got[3], got[2:1], got[0],
                  ov, od, ol, fe, ec, dr);
      end
   endtask

   initial begin
      bit seen;

      // good frame, ready high
      add(1,8'hA5,1, 0,8'h00,0, 0,0,0);
      add(1,8'h03,1, 0,8'h00,0, 0,0,0);
      add(1,8'h11,1, 0,8'h00,0, 0,0,0);
      add(1,8'h22,1, 0,8'h00,0, 0,0,0);
      add(1,8'h33,1, 0,8'h00,0, 0,0,0);
      add(1,8'h03,1, 1,8'h11,0, 0,0,0);
      add(0,8'h00,1, 1,8'h22,0, 0,0,0);
      add(0,8'h00,1, 1,8'h33,1, 0,0,0);
      add(0,8'h00,1, 0,8'h00,0, 0,0,0);
      // same frame with backpressure
      add(1,8'hA5,0, 0,8'h00,0, 0,0,0);
      add(1,8'h03,0, 0,8'h00,0, 0,0,0);
      add(1,8'h11,0, 0,8'h00,0, 0,0,0);
      add(1,8'h22,0, 0,8'h00,0, 0,0,0);
      add(1,8'h33,0, 0,8'h00,0, 0,0,0);
      add(1,8'h03,0, 1,8'h11,0, 0,0,0);
      add(0,8'h00,0, 1,8'h11,0, 0,0,0);
      add(0,8'h00,1, 1,8'h22,0, 0,0,0);
      add(0,8'h00,0, 1,8'h22,0, 0,0,0);
      add(0,8'h00,1, 1,8'h33,1, 0,0,0);
      add(0,8'h00,0, 1,8'h33,1, 0,0,0);
      add(0,8'h00,1, 0,8'h00,0, 0,0,0);
      // checksum error, then good one-byte frame
      add(1,8'hA5,0, 0,8'h00,0, 0,0,0);
      add(1,8'h02,0, 0,8'h00,0, 0,0,0);
      add(1,8'h10,0, 0,8'h00,0, 0,0,0);
      add(1,8'h20,0, 0,8'h00,0, 0,0,0);
      add(1,8'h00,0, 0,8'h00,0, 1,2,0);
      add(0,8'h00,0, 0,8'h00,0, 0,2,0);
      add(1,8'hA5,0, 0,8'h00,0, 0,2,0);
      add(1,8'h01,0, 0,8'h00,0, 0,2,0);
      add(1,8'h7E,0, 0,8'h00,0, 0,2,0);
      add(1,8'h7F,0, 1,8'h7E,1, 0,2,0);
      add(0,8'h00,1, 0,8'h00,0, 0,2,0);
      // bad lengths and leading garbage
      add(1,8'hA5,0, 0,8'h00,0, 0,2,0);
      add(1,8'h00,0, 0,8'h00,0, 1,1,0);
      add(0,8'h00,0, 0,8'h00,0, 0,1,0);
      add(1,8'hA5,0, 0,8'h00,0, 0,1,0);
      add(1,8'h11,0, 0,8'h00,0, 1,1,0);
      add(0,8'h00,0, 0,8'h00,0, 0,1,0);
      add(1,8'h00,0, 0,8'h00,0, 0,1,0);
      add(1,8'hFF,0, 0,8'h00,0, 0,1,0);
      add(1,8'hA5,0, 0,8'h00,0, 0,1,0);
      add(1,8'h01,0, 0,8'h00,0, 0,1,0);
      add(1,8'h55,0, 0,8'h00,0, 0,1,0);
      add(1,8'h54,0, 1,8'h55,1, 0,1,0);
      add(0,8'h00,1, 0,8'h00,0, 0,1,0);
      // sync as payload data, drops during SEND
      add(1,8'hA5,0, 0,8'h00,0, 0,1,0);
      add(1,8'h02,0, 0,8'h00,0, 0,1,0);
      add(1,8'hC3,0, 0,8'h00,0, 0,1,0);
      add(1,8'hA5,0, 0,8'h00,0, 0,1,0);
      add(1,8'h64,0, 1,8'hC3,0, 0,1,0);
      add(1,8'hA5,0, 1,8'hC3,0, 0,1,1);
      add(1,8'h12,0, 1,8'hC3,0, 0,1,1);
      add(0,8'h00,0, 1,8'hC3,0, 0,1,0);
      add(0,8'h00,1, 1,8'hA5,1, 0,1,0);
      add(0,8'h00,1, 0,8'h00,0, 0,1,0);
      add(0,8'h00,1, 0,8'h00,0, 0,1,0);

      rst = 1'b1;
      step(0, 8'h00, 0);
      step(0, 8'h00, 0);
      rst = 1'b0;
      chk("reset", 0, 8'h00, 0, 0, 0, 0);

      foreach (tv[i]) begin
         step(tv[i].v, tv[i].d, tv[i].r);
         chk($sformatf("vec%0d", i), tv[i].ov, tv[i].od, tv[i].ol,
             tv[i].fe, tv[i].ec, tv[i].dr);
      end

      // timeout: error on exactly the TO-th idle cycle
      step(1, 8'hA5, 0);
      step(1, 8'h02, 0);
      step(1, 8'h10, 0);
      seen = 1'b0;
      for (int k = 1; k < TO; k++) begin
         step(0, 8'h00, 0);
         if (frame_err) seen = 1'b1;
      end
      n_cmp++;
      if (seen) begin
         n_bad++;
         $display("FAIL tmo_early: got frame_err before limit, need none");
      end
      step(0, 8'h00, 0);
      chk("tmo_fire", 0, 8'h00, 0, 1, 3, 0);
      step(0, 8'h00, 0);
      chk("tmo_after", 0, 8'h00, 0, 0, 3, 0);

      // byte arriving on the limit cycle beats the timeout
      step(1, 8'hA5, 0);
      step(1, 8'h02, 0);
      step(1, 8'h10, 0);
      for (int k = 1; k < TO; k++) step(0, 8'h00, 0);
      step(1, 8'h20, 0);
      chk("tmo_win", 0, 8'h00, 0, 0, 3, 0);
      step(1, 8'h32, 0);
      chk("tmo_win_d0", 1, 8'h10, 0, 0, 3, 0);
      step(0, 8'h00, 1);
      chk("tmo_win_d1", 1, 8'h20, 1, 0, 3, 0);
      step(0, 8'h00, 1);
      chk("tmo_win_end", 0, 8'h00, 0, 0, 3, 0);

      // reset mid-payload
      step(1, 8'hA5, 0);
      step(1, 8'h03, 0);
      step(1, 8'h11, 0);
      rst = 1'b1;
      step(0, 8'h00, 0);
      rst = 1'b0;
      chk("rst_mid", 0, 8'h00, 0, 0, 0, 0);
      step(1, 8'hA5, 0);
      step(1, 8'h01, 0);
      step(1, 8'h7E, 0);
      step(1, 8'h7F, 0);
      chk("rst_next", 1, 8'h7E, 1, 0, 0, 0);

      // reset mid-SEND
      rst = 1'b1;
      step(0, 8'h00, 0);
      rst = 1'b0;
      chk("rst_send", 0, 8'h00, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, need finish");
      $fatal(1, "watchdog");
   end

endmodule
